// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Bus bundle between the fetch stage and its neighbours
//               (debug-unit loader, decode-stage redirect and the IF/ID outputs).
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if #(
    parameter int PC_SIZE  = 32,
    parameter int BUS_SIZE = 32
);
    logic                i_enable;
    logic                i_stall;
    logic                i_next_pc_src;
    logic [PC_SIZE-1:0]  i_next_not_seq_pc;
    logic                i_inst_wr_en;
    logic [BUS_SIZE-1:0] i_inst_bus_wr;
    logic                i_clear_mem;
    logic [BUS_SIZE-1:0] o_instruction;
    logic [PC_SIZE-1:0]  o_next_seq_pc;
    logic [PC_SIZE-1:0]  o_pc;
    logic                o_halt;
    logic                o_mem_full;
    logic                o_mem_empty;

    modport master (
        output i_enable, i_stall, i_next_pc_src, i_next_not_seq_pc,
        output i_inst_wr_en, i_inst_bus_wr, i_clear_mem,
        input  o_instruction, o_next_seq_pc, o_pc, o_halt, o_mem_full, o_mem_empty
    );

    modport slave (
        input  i_enable, i_stall, i_next_pc_src, i_next_not_seq_pc,
        input  i_inst_wr_en, i_inst_bus_wr, i_clear_mem,
        output o_instruction, o_next_seq_pc, o_pc, o_halt, o_mem_full, o_mem_empty
    );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : MIPS instruction-fetch stage with IF/ID register, loadable
//               instruction memory and HALT detection.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter int                  PC_SIZE   = 32,
    parameter int                  BUS_SIZE  = 32,
    parameter int                  MEM_WORDS = 64,
    parameter logic [BUS_SIZE-1:0] HALT_CODE = {BUS_SIZE{1'b1}}
) (
    input  wire        i_clk,
    input  wire        i_reset,
    if_stage_if.slave  bus
);
    localparam int c_ADDR_W = $clog2(MEM_WORDS);
    localparam int c_PTR_W  = c_ADDR_W + 1;

    logic [BUS_SIZE-1:0] r_mem [0:MEM_WORDS-1];
    logic [PC_SIZE-1:0]  r_pc;
    logic [BUS_SIZE-1:0] r_instruction;
    logic [PC_SIZE-1:0]  r_next_seq_pc;
    logic [c_PTR_W-1:0]  r_ptr;
    logic                r_halt;

    logic [c_ADDR_W-1:0] w_index;
    logic                w_valid;
    logic [BUS_SIZE-1:0] w_fetch;
    logic [PC_SIZE-1:0]  w_pc_plus4;
    logic                w_full;
    logic                w_empty;
    logic                w_mem_we;

    assign w_index    = r_pc[c_ADDR_W+1:2];
    // Unloaded words and misaligned PCs both read as HALT so runaway fetch stops.
    assign w_valid    = ({1'b0, w_index} < r_ptr) && (r_pc[1:0] == 2'b00);
    assign w_fetch    = w_valid ? r_mem[w_index] : HALT_CODE;
    assign w_pc_plus4 = r_pc + PC_SIZE'(4);
    assign w_full     = (r_ptr == c_PTR_W'(MEM_WORDS));
    assign w_empty    = (r_ptr == '0);
    assign w_mem_we   = i_reset && !bus.i_enable && !bus.i_clear_mem
                        && bus.i_inst_wr_en && !w_full;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[r_ptr[c_ADDR_W-1:0]] <= bus.i_inst_bus_wr;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc          <= '0;
            r_instruction <= '0;
            r_next_seq_pc <= '0;
            r_ptr         <= '0;
            r_halt        <= 1'b0;
        end else if (bus.i_enable) begin
            if (!r_halt && !bus.i_stall) begin
                r_next_seq_pc <= w_pc_plus4;
                if (bus.i_next_pc_src) begin
                    // Squash the wrong-path word with a NOP; no delay slot.
                    r_pc          <= bus.i_next_not_seq_pc;
                    r_instruction <= '0;
                end else begin
                    r_instruction <= w_fetch;
                    if (w_fetch == HALT_CODE) begin
                        r_halt <= 1'b1;
                    end else begin
                        r_pc <= w_pc_plus4;
                    end
                end
            end
        end else if (bus.i_clear_mem) begin
            r_ptr  <= '0;
            r_halt <= 1'b0;
        end else if (bus.i_inst_wr_en && !w_full) begin
            r_ptr <= r_ptr + c_PTR_W'(1);
        end
    end

    assign bus.o_instruction = r_instruction;
    assign bus.o_next_seq_pc = r_next_seq_pc;
    assign bus.o_pc          = r_pc;
    assign bus.o_halt        = r_halt;
    assign bus.o_mem_full    = w_full;
    assign bus.o_mem_empty   = w_empty;
endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;
    localparam int          c_MEM_WORDS = 64;
    localparam logic [31:0] c_HALT      = 32'hFFFF_FFFF;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    if_stage_if #(.PC_SIZE(32), .BUS_SIZE(32)) bus ();

    if_stage #(
        .PC_SIZE  (32),
        .BUS_SIZE (32),
        .MEM_WORDS(c_MEM_WORDS),
        .HALT_CODE(c_HALT)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic write_word(input logic [31:0] data);
        bus.i_inst_wr_en  = 1'b1;
        bus.i_inst_bus_wr = data;
        step();
        bus.i_inst_wr_en  = 1'b0;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] nsp, input logic [31:0] pc);
        chk({tag, "_instr"}, bus.o_instruction, instr);
        chk({tag, "_nsp"},   bus.o_next_seq_pc, nsp);
        chk({tag, "_pc"},    bus.o_pc,          pc);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.i_enable          = 1'b0;
        bus.i_stall           = 1'b0;
        bus.i_next_pc_src     = 1'b0;
        bus.i_next_not_seq_pc = '0;
        bus.i_inst_wr_en      = 1'b0;
        bus.i_inst_bus_wr     = '0;
        bus.i_clear_mem       = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        check_ifid("rst", 32'h0, 32'h0, 32'h0);
        chk("rst_halt",  32'(bus.o_halt),      32'h0);
        chk("rst_empty", 32'(bus.o_mem_empty), 32'h1);
        chk("rst_full",  32'(bus.o_mem_full),  32'h0);

        // T1: three words, then fetch runs into the unloaded region
        write_word(32'hAAAA_0001);
        write_word(32'hBBBB_0002);
        write_word(32'hCCCC_0003);
        chk("t1_empty", 32'(bus.o_mem_empty), 32'h0);
        bus.i_enable = 1'b1;
        step(); check_ifid("t1_a", 32'hAAAA_0001, 32'd4,  32'd4);
        step(); check_ifid("t1_b", 32'hBBBB_0002, 32'd8,  32'd8);
        step(); check_ifid("t1_c", 32'hCCCC_0003, 32'd12, 32'd12);
        step(); check_ifid("t1_h", c_HALT,        32'd16, 32'd12);
        chk("t1_halt", 32'(bus.o_halt), 32'h1);
        step(); check_ifid("t1_hold", c_HALT,     32'd16, 32'd12);
        bus.i_enable    = 1'b0;
        bus.i_clear_mem = 1'b1;
        step();
        bus.i_clear_mem = 1'b0;
        chk("t1_clr_halt",  32'(bus.o_halt),      32'h0);
        chk("t1_clr_empty", 32'(bus.o_mem_empty), 32'h1);

        // T2: redirect to 0x20 at PC=4
        pulse_reset();
        for (int i = 0; i < 16; i++) write_word(32'h1000_0000 + 32'(i));
        bus.i_enable = 1'b1;
        step(); check_ifid("t2_w0", 32'h1000_0000, 32'd4, 32'd4);
        bus.i_next_pc_src     = 1'b1;
        bus.i_next_not_seq_pc = 32'h20;
        step();
        bus.i_next_pc_src = 1'b0;
        check_ifid("t2_nop", 32'h0, 32'd8, 32'h20);
        step(); check_ifid("t2_tgt", 32'h1000_0008, 32'h24, 32'h24);

        // T3: two stall cycles, redirect offered during the first
        bus.i_stall           = 1'b1;
        bus.i_next_pc_src     = 1'b1;
        bus.i_next_not_seq_pc = 32'h40;
        step();
        bus.i_next_pc_src = 1'b0;
        check_ifid("t3_s1", 32'h1000_0008, 32'h24, 32'h24);
        step(); check_ifid("t3_s2", 32'h1000_0008, 32'h24, 32'h24);
        bus.i_stall = 1'b0;
        step(); check_ifid("t3_go", 32'h1000_0009, 32'h28, 32'h28);

        // T6: misaligned target fetches HALT
        bus.i_next_pc_src     = 1'b1;
        bus.i_next_not_seq_pc = 32'h2;
        step();
        bus.i_next_pc_src = 1'b0;
        check_ifid("t6_nop", 32'h0, 32'h2c, 32'h2);
        step(); check_ifid("t6_h", c_HALT, 32'h6, 32'h2);
        chk("t6_halt", 32'(bus.o_halt), 32'h1);

        // T5: asynchronous reset mid-run at PC=8
        bus.i_enable = 1'b0;
        pulse_reset();
        for (int i = 0; i < 16; i++) write_word(32'h1000_0000 + 32'(i));
        bus.i_enable = 1'b1;
        step();
        step(); check_ifid("t5_run", 32'h1000_0001, 32'd8, 32'd8);
        rst_n = 1'b0;
        #2;
        check_ifid("t5_async", 32'h0, 32'h0, 32'h0);
        chk("t5_empty", 32'(bus.o_mem_empty), 32'h1);
        rst_n = 1'b1;
        step(); check_ifid("t5_h", c_HALT, 32'd4, 32'd0);
        chk("t5_halt", 32'(bus.o_halt), 32'h1);
        // Loader inputs are ignored while enabled
        write_word(32'h5555_5555);
        chk("t5_ign_empty", 32'(bus.o_mem_empty), 32'h1);

        // T4: fill memory, overflow write, read back last word, clear
        bus.i_enable = 1'b0;
        pulse_reset();
        for (int i = 0; i < c_MEM_WORDS - 1; i++) write_word(32'h2000_0000 + 32'(i));
        chk("t4_notfull", 32'(bus.o_mem_full), 32'h0);
        write_word(32'h2000_0000 + 32'(c_MEM_WORDS - 1));
        chk("t4_full", 32'(bus.o_mem_full), 32'h1);
        write_word(32'hDEAD_BEEF);
        chk("t4_full2", 32'(bus.o_mem_full), 32'h1);
        bus.i_enable          = 1'b1;
        bus.i_next_pc_src     = 1'b1;
        bus.i_next_not_seq_pc = 32'hFC;
        step();
        bus.i_next_pc_src = 1'b0;
        check_ifid("t4_jmp", 32'h0, 32'd4, 32'hFC);
        step(); check_ifid("t4_last", 32'h2000_003F, 32'h100, 32'h100);
        bus.i_enable    = 1'b0;
        bus.i_clear_mem = 1'b1;
        step();
        bus.i_clear_mem = 1'b0;
        chk("t4_clr_empty", 32'(bus.o_mem_empty), 32'h1);
        chk("t4_clr_full",  32'(bus.o_mem_full),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
